fft_reorder_8: RTL and testbench

FFT_REORDER_8 -- requirements
Module: fft_reorder_8

---
 rtl/fft_reorder_8.sv | 115 +++++++++++
 tb/tb_fft_reorder_8.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fft_reorder_8.sv
// Ping-pong reorder buffer for an 8-point FFT. Bit-reversed input frames become
// natural-order output frames with valid/ready handshaking and a sticky overflow flag.
module fft_reorder_8 (
    input  logic       clk,
    input  logic       clear,
    input  logic       in_valid,
    input  logic       in_sof,
    input  logic [3:0] in_data,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] out_data,
    output logic [2:0] out_index,
    output logic       out_last,
    output logic       overflow
);

    function automatic logic [2:0] bitrev3(input logic [2:0] v);
        bitrev3 = {v[0], v[1], v[2]};
    endfunction

    // Word address is {bank, offset}; bank 0 is words 0..7 and bank 1 is words 8..15.
    logic [3:0] mem_r [0:15];
    logic [1:0] full_r;
    logic       wr_bank_r;
    logic       rd_bank_r;
    logic [2:0] wr_cnt_r;
    logic [2:0] rd_cnt_r;
    logic       overflow_r;

    logic [2:0] k_s;
    logic       accept_s;
    logic       drop_s;
    logic       rd_fire_s;
    logic [1:0] full_s;

    // Write/read event decode and next full flags, all computed from pre-edge state.
    always_comb begin
        k_s       = in_sof ? 3'd0 : wr_cnt_r;
        accept_s  = in_valid && !full_r[wr_bank_r];
        drop_s    = in_valid && full_r[wr_bank_r];
        rd_fire_s = full_r[rd_bank_r] && out_ready;
        full_s    = full_r;
        // Read and write complete on different banks, so both updates can apply together.
        if (rd_fire_s && (rd_cnt_r == 3'd7)) begin
            full_s[rd_bank_r] = 1'b0;
        end else begin
            full_s = full_s;
        end
        if (accept_s && (k_s == 3'd7)) begin
            full_s[wr_bank_r] = 1'b1;
        end else begin
            full_s = full_s;
        end
    end

    // Buffer storage and pointer state. The synchronous clear takes priority over every event.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < 16; i++) begin
                mem_r[i] <= 4'h0;
            end
            full_r     <= 2'b00;
            wr_bank_r  <= 1'b0;
            rd_bank_r  <= 1'b0;
            wr_cnt_r   <= 3'd0;
            rd_cnt_r   <= 3'd0;
            overflow_r <= 1'b0;
        end else begin
            full_r <= full_s;
            if (accept_s) begin
                mem_r[{wr_bank_r, bitrev3(k_s)}] <= in_data;
                wr_cnt_r <= k_s + 3'd1;
                if (k_s == 3'd7) begin
                    wr_bank_r <= ~wr_bank_r;
                end else begin
                    wr_bank_r <= wr_bank_r;
                end
            end else begin
                wr_cnt_r  <= wr_cnt_r;
                wr_bank_r <= wr_bank_r;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
            if (rd_fire_s) begin
                rd_cnt_r <= rd_cnt_r + 3'd1;
                if (rd_cnt_r == 3'd7) begin
                    rd_bank_r <= ~rd_bank_r;
                end else begin
                    rd_bank_r <= rd_bank_r;
                end
            end else begin
                rd_cnt_r  <= rd_cnt_r;
                rd_bank_r <= rd_bank_r;
            end
        end
    end

    // Output view; every output is decoded from registered state alone.
    always_comb begin
        out_valid = full_r[rd_bank_r];
        out_index = rd_cnt_r;
        overflow  = overflow_r;
        if (out_valid) begin
            out_data = mem_r[{rd_bank_r, rd_cnt_r}];
            out_last = (rd_cnt_r == 3'd7);
        end else begin
            out_data = 4'h0;
            out_last = 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_reorder_8.sv
// Directed scoreboard bench for fft_reorder_8: stimulus pushes expected natural-order
// samples, a negedge monitor pops and compares every accepted output.
module tb_fft_reorder_8;

    logic       clk = 1'b0;
    logic       clear;
    logic       in_valid;
    logic       in_sof;
    logic [3:0] in_data;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic [2:0] out_index;
    logic       out_last;
    logic       overflow;

    int checks = 0;
    int fails  = 0;
    int gaps   = 0;
    logic started = 1'b0;
    logic [7:0] q [$];

    fft_reorder_8 dut (
        .clk       (clk),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] brev(input logic [2:0] v);
        brev = {v[0], v[1], v[2]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake pops one expected {last, index, data}.
    always @(negedge clk) begin
        if (!clear && out_valid) started <= 1'b1;
        if (!clear && started && !out_valid && q.size() > 0) gaps++;
        if (!clear && out_valid && out_ready) begin
            logic [7:0] e;
            if (q.size() == 0) begin
                chk("unexpected_output", {24'd0, out_last, out_index, out_data}, 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                chk("out_data", {28'd0, out_data}, {28'd0, e[3:0]});
                chk("out_index", {29'd0, out_index}, {29'd0, e[6:4]});
                chk("out_last", {31'd0, out_last}, {31'd0, e[7]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] base, input int k0, input int n, input logic sof);
        for (int k = k0; k < k0 + n; k++) begin
            logic [2:0] kk;
            kk = k[2:0];
            in_valid = 1'b1;
            in_sof   = sof && (k == k0);
            in_data  = {1'b0, brev(kk)} + base;
            tick();
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic expect_frame(input logic [3:0] base);
        for (int n = 0; n < 8; n++) begin
            logic [2:0] nn;
            logic [3:0] d;
            nn = n[2:0];
            d  = {1'b0, nn} + base;
            q.push_back({(n == 7), nn, d});
        end
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (q.size() > 0 && t < 200) begin
            tick();
            t++;
        end
        chk(name, q.size(), 32'd0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        q.delete();
        started = 1'b0;
    endtask

    initial begin
        clear = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = 4'h0; out_ready = 1'b1;
        tick(); tick();
        clear = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {28'd0, out_data}, 32'd0);
        chk("rst_out_index", {29'd0, out_index}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);

        // Single frame, latency
        send(4'd8, 0, 7, 1'b1);
        chk("lat_not_yet", {31'd0, out_valid}, 32'd0);
        send(4'd8, 7, 1, 1'b0);
        expect_frame(4'd8);
        chk("lat_valid", {31'd0, out_valid}, 32'd1);
        drain("single_drain");

        // Back-to-back, no gaps
        gaps = 0;
        send(4'd1, 0, 8, 1'b1);  expect_frame(4'd1);
        send(4'd5, 0, 8, 1'b1);  expect_frame(4'd5);
        send(4'd11, 0, 8, 1'b1); expect_frame(4'd11);
        drain("b2b_drain");
        chk("b2b_gaps", gaps, 32'd0);
        chk("b2b_overflow", {31'd0, overflow}, 32'd0);

        // Backpressure and overflow
        out_ready = 1'b0;
        send(4'd2, 0, 8, 1'b1);  expect_frame(4'd2);
        send(4'd7, 0, 8, 1'b1);  expect_frame(4'd7);
        send(4'd12, 0, 8, 1'b1);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        chk("bp_hold_index", {29'd0, out_index}, 32'd0);
        out_ready = 1'b1;
        drain("bp_drain");
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        do_clear();
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Resync on in_sof mid-frame
        send(4'd3, 0, 5, 1'b1);
        send(4'd9, 0, 8, 1'b1);  expect_frame(4'd9);
        drain("resync_drain");

        // Stall pattern 1,0,0,1
        send(4'd4, 0, 8, 1'b1);  expect_frame(4'd4);
        out_ready = 1'b1; tick();
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            chk("stall_index", {29'd0, out_index}, 32'd1);
            chk("stall_data", {28'd0, out_data}, 32'd5);
            if (s < 2) tick();
        end
        out_ready = 1'b1;
        drain("stall_drain");

        // Clear mid-readout
        send(4'd6, 0, 8, 1'b1);  expect_frame(4'd6);
        tick(); tick(); tick();
        chk("mid_index", {29'd0, out_index}, 32'd3);
        out_ready = 1'b0;
        do_clear();
        chk("clr_out_valid", {31'd0, out_valid}, 32'd0);
        chk("clr_overflow", {31'd0, overflow}, 32'd0);
        out_ready = 1'b1;
        send(4'd13, 0, 8, 1'b1); expect_frame(4'd13);
        chk("clr_restart_index", {29'd0, out_index}, 32'd0);
        drain("clr_drain");
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
